// File: rtl/addr_reg_bank_if.sv
// addr_reg_bank_if: operand, control and read-port bundle of the address register bank.
// Handshake: none. Control inputs are sampled on every rising clock edge, and the
// read ports are purely combinational, so no valid/ready pair is carried.
interface addr_reg_bank_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
);
  localparam int SELW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [WIDTH-1:0]    I;
  logic [2:0]          FunSel;
  logic [NUM_REGS-1:0] RegSel;
  logic [SELW-1:0]     OutCSel;
  logic [SELW-1:0]     OutDSel;
  logic                FlagClr;
  logic [WIDTH-1:0]    OutC;
  logic [WIDTH-1:0]    OutD;
  logic                StackOvf;
  logic                StackUnf;

  modport master (
    output I, FunSel, RegSel, OutCSel, OutDSel, FlagClr,
    input  OutC, OutD, StackOvf, StackUnf
  );

  modport slave (
    input  I, FunSel, RegSel, OutCSel, OutDSel, FlagClr,
    output OutC, OutD, StackOvf, StackUnf
  );
endinterface

// File: rtl/addr_reg_bank.sv
// addr_reg_bank: NUM_REGS address registers (PC at index 0, SP at SP_IDX)
// sharing one 3-bit function code, with per-register enables and two
// combinational read ports.
// Optional feature macro: ADDR_REG_BANK_STACK_CHECK_EN enables the stack-bounds
// checker on register SP_IDX (blocked SP update plus sticky StackOvf/StackUnf).
module addr_reg_bank #(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 4,
  parameter int               SP_IDX      = NUM_REGS - 1,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] STACK_BASE  = '1,
  parameter logic [WIDTH-1:0] STACK_LIMIT = {{(WIDTH-8){1'b1}}, 8'h00}
) (
  input  logic          Clock,
  input  logic          Reset,
  addr_reg_bank_if.slave bus
);
  localparam int SELW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int HALF = WIDTH / 2;
  localparam logic [SELW:0] NREGS_W = (SELW + 1)'(NUM_REGS);

  if (NUM_REGS < 2 || NUM_REGS > 16 || SP_IDX == 0 || SP_IDX >= NUM_REGS ||
      WIDTH < 8 || (WIDTH % 2) != 0 || STACK_LIMIT > STACK_BASE) begin : g_param_err
    $error("addr_reg_bank: illegal parameter combination");
  end

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  // One function applied to a register's own current value.
  function automatic logic [WIDTH-1:0] apply_fun(input logic [2:0] fun,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] res;
    case (fun)
      3'b000:  res = r - WIDTH'(1);
      3'b001:  res = r + WIDTH'(1);
      3'b010:  res = d;
      3'b011:  res = '0;
      3'b100:  res = r + d;
      3'b101:  res = r - d;
      3'b110:  res = {r[WIDTH-1:HALF], d[HALF-1:0]};
      default: res = {d[HALF-1:0], r[HALF-1:0]};
    endcase
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] rst_val(input int k);
    if (k == 0)           return RESET_PC;
    else if (k == SP_IDX) return STACK_BASE;
    else                  return '0;
  endfunction

`ifdef ADDR_REG_BANK_STACK_CHECK_EN
  localparam logic [WIDTH:0] ONE_W = (WIDTH + 1)'(1);
  logic [WIDTH:0] sp_wide;
  logic           ovf_set;
  logic           unf_set;
  logic           ovf_q;
  logic           unf_q;
`endif

  // Next-state: every enabled register takes the function; a stack violation reverts SP only.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (bus.RegSel[k]) regs_d[k] = apply_fun(bus.FunSel, regs_q[k], bus.I);
    end
`ifdef ADDR_REG_BANK_STACK_CHECK_EN
    sp_wide = '0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.RegSel[SP_IDX]) begin
      case (bus.FunSel)
        3'b000, 3'b101: begin
          // Borrow lands in the extra top bit.
          sp_wide = {1'b0, regs_q[SP_IDX]} - ((bus.FunSel == 3'b000) ? ONE_W : {1'b0, bus.I});
          if (sp_wide[WIDTH] || (sp_wide[WIDTH-1:0] < STACK_LIMIT)) begin
            regs_d[SP_IDX] = regs_q[SP_IDX];
            ovf_set        = 1'b1;
          end
        end
        3'b001, 3'b100: begin
          sp_wide = {1'b0, regs_q[SP_IDX]} + ((bus.FunSel == 3'b001) ? ONE_W : {1'b0, bus.I});
          if (sp_wide[WIDTH] || (sp_wide[WIDTH-1:0] > STACK_BASE)) begin
            regs_d[SP_IDX] = regs_q[SP_IDX];
            unf_set        = 1'b1;
          end
        end
        default: ;
      endcase
    end
`endif
  end

  // Register state; synchronous reset overrides any operation in the same cycle.
  always_ff @(posedge Clock) begin
    for (int k = 0; k < NUM_REGS; k++) begin
      if (Reset) regs_q[k] <= rst_val(k);
      else       regs_q[k] <= regs_d[k];
    end
  end

`ifdef ADDR_REG_BANK_STACK_CHECK_EN
  // Sticky flags: a new violation wins over a simultaneous clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~bus.FlagClr) | ovf_set;
      unf_q <= (unf_q & ~bus.FlagClr) | unf_set;
    end
  end

  assign bus.StackOvf = ovf_q;
  assign bus.StackUnf = unf_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = bus.FlagClr;
  assign bus.StackOvf    = 1'b0;
  assign bus.StackUnf    = 1'b0;
`endif

  // Read ports: combinational, out-of-range select reads zero.
  always_comb begin
    bus.OutC = '0;
    bus.OutD = '0;
    if ({1'b0, bus.OutCSel} < NREGS_W) bus.OutC = regs_q[bus.OutCSel];
    if ({1'b0, bus.OutDSel} < NREGS_W) bus.OutD = regs_q[bus.OutDSel];
  end
endmodule

// File: doc/addr_reg_bank.md
# addr_reg_bank

Parametrised address register bank for the datapath's address side: NUM_REGS registers of WIDTH bits holding the program counter, address register, stack pointer and any extra pointer registers. Each register updates synchronously under a shared 3-bit function code with a per-register active-high enable. Two independent combinational read ports feed the memory address and ALU muxes. An optional stack-bounds checker guards the stack-pointer register against overflow and underflow.

## Interface
- WIDTH, 16, register and data width in bits (≥8, even)
- NUM_REGS, 4, number of registers (2..16); index 0 = PC
- SP_IDX, NUM_REGS-1, index of the stack-pointer register
- RESET_PC, 0, reset value of register 0
- STACK_BASE, 16'hFFFF (WIDTH bits), SP reset value and highest legal SP (stack grows down)
- STACK_LIMIT, 16'hFF00 (WIDTH bits), lowest legal SP; requires STACK_LIMIT ≤ STACK_BASE
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- I  in  WIDTH  load/operand data
- FunSel  in  3  function code applied to every enabled register
- RegSel  in  NUM_REGS  per-register enable, active-high, bit k = register k
- OutCSel  in  SELW = max(1,$clog2(NUM_REGS))  read-port C select
- OutDSel  in  SELW  read-port D select
- FlagClr  in  1  clears sticky stack flags
- OutC  out  WIDTH  contents of register OutCSel
- OutD  out  WIDTH  contents of register OutDSel
- StackOvf  out  1  sticky: push/decrement below STACK_LIMIT blocked
- StackUnf  out  1  sticky: pop/increment above STACK_BASE blocked

## Operation
- FunSel codes (R = enabled register, arithmetic modulo 2^WIDTH): 000 R−1; 001 R+1; 010 R←I; 011 R←0; 100 R+I; 101 R−I; 110 R[WIDTH/2-1:0]←I[WIDTH/2-1:0], upper half kept; 111 R[WIDTH-1:WIDTH/2]←I[WIDTH/2-1:0], lower half kept.
- RegSel bit 0: register holds regardless of FunSel. Any number of bits may be set; all selected registers take the same function from their own current value.
- Read ports: purely combinational from current register state; OutCSel/OutDSel ≥ NUM_REGS returns 0. Both ports may select the same register.
- Reads show pre-edge value; a write is visible on OutC/OutD after the edge.
- Stack check (macro enabled, register SP_IDX only, only when RegSel[SP_IDX]=1):
  - codes 000/101: compute in WIDTH+1 bits; if result < STACK_LIMIT or borrow occurs -> SP unchanged, StackOvf←1.
  - codes 001/100: if result > STACK_BASE or carry occurs -> SP unchanged, StackUnf←1.
  - codes 010, 011, 110, 111 unchecked (software may place SP anywhere).
- Flags: sticky until Reset or FlagClr. FlagClr and new violation in same cycle: flag ends 1.
- Blocked SP update does not affect other registers enabled in the same cycle.

## Timing
- Register update latency: 1 cycle (value at edge n visible after edge n).
- Read latency: 0 (combinational).
- Reset (sync, wins over all other inputs): reg 0←RESET_PC, reg SP_IDX←STACK_BASE, all others←0, StackOvf=StackUnf=0. OutC/OutD after reset reflect those values per select. Reset asserted mid-sequence discards that cycle's operation.
- SP_IDX=0 is illegal (elaboration error); NUM_REGS<2 illegal.

## Configuration
- ADDR_REG_BANK_STACK_CHECK_EN defined: stack checker, blocking and sticky flags as above.
- Undefined: SP_IDX behaves like any other register (free wrap), StackOvf/StackUnf tied 0, FlagClr ignored; SP still resets to STACK_BASE.

## Test plan
- Reset, NUM_REGS=4, RESET_PC=16'h0020 -> OutCSel=0 reads 16'h0020, OutDSel=3 reads 16'hFFFF, OutCSel=1 reads 0, flags 0.
- RegSel=4'b0011, FunSel=010, I=16'h1234; then FunSel=001 -> reg0=reg1=16'h1235, reg2 unchanged 0; OutCSel=0/OutDSel=1 both 16'h1235.
- reg1=16'hABCD, FunSel=110 I=16'h0012 -> 16'hAB12; FunSel=111 I=16'h0034 -> 16'h3412; reg1=0 FunSel=000 -> 16'hFFFF (wrap).
- Macro on: SP=16'hFF00, FunSel=000 -> SP stays 16'hFF00, StackOvf=1 next cycle; FunSel=001 -> SP=16'hFF01, StackOvf still 1; FlagClr -> 0.
- Macro on: SP=16'hFFFF, FunSel=100 I=16'h0002 with RegSel also enabling reg0=16'h0010 -> SP unchanged, StackUnf=1, reg0=16'h0012; same cycle FlagClr=1 -> StackUnf=1.
- Macro off: SP=16'hFF00, FunSel=000 -> SP=16'hFEFF, flags 0; Reset mid-sequence with FunSel=010 -> reset values win.
